dct_stream_fifo: RTL and testbench

Parametrised synchronous FIFO for buffering coefficient and partial-product streams between stages of the 2D DCT datapath (row transform, transpose, column transform). It is the general-purpose successor of the fixed 36-bit x 4 multiplier FIFO. It adds configurable width and depth, exact occupancy, almost-full/almost-empty thresholds, a selectable first-word-fall-through read mode, and sticky overflow/underflow error flags.

---
 rtl/dct_stream_fifo_if.sv | 34 +++
 rtl/dct_stream_fifo.sv | 110 +++++++++++
 tb/tb_dct_stream_fifo.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/dct_stream_fifo_if.sv
// Handshake bundle between a DCT pipeline stage and its stream FIFO.
// The master side is the producer/consumer pair; the slave side is the FIFO.
interface dct_stream_fifo_if #(
  parameter int DATA_W = 36,
  parameter int DEPTH  = 4
);
  localparam int AW = $clog2(DEPTH);

  logic              wr_en;
  logic [DATA_W-1:0] din;
  logic              rd_en;
  logic              clr_err;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [AW:0]       level;
  logic              overflow;
  logic              underflow;

  modport master (
    output wr_en, din, rd_en, clr_err,
    input  dout, dout_valid, full, empty, almost_full, almost_empty,
           level, overflow, underflow
  );

  modport slave (
    input  wr_en, din, rd_en, clr_err,
    output dout, dout_valid, full, empty, almost_full, almost_empty,
           level, overflow, underflow
  );
endinterface

// File: rtl/dct_stream_fifo.sv
// Parametrised synchronous FIFO for DCT coefficient/partial-product streams,
// with exact occupancy, threshold flags, optional FWFT and sticky error flags.
module dct_stream_fifo #(
  parameter int DATA_W   = 36,
  parameter int DEPTH    = 4,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1,
  parameter int FWFT     = 0
) (
  input logic               clk,
  input logic               rst,
  dct_stream_fifo_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_LVL   = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0] AE_LVL   = (AW+1)'(AE_LEVEL);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       level_q, level_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              af_q, af_d;
  logic              ae_q, ae_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              dvalid_q, dvalid_d;
  logic              wr_acc, rd_acc;
  logic [DATA_W-1:0] head;

  always_comb begin
    wr_acc   = bus.wr_en & ~full_q;
    rd_acc   = bus.rd_en & ~empty_q;
    head     = mem_q[rd_ptr_q];
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    dout_d   = dout_q;
    dvalid_d = 1'b0;

    if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_acc) rd_ptr_d = rd_ptr_q + AW'(1);

    case ({wr_acc, rd_acc})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase

    // Flags come from the next level so they are exact right after the edge.
    full_d  = (level_d == FULL_LVL);
    empty_d = (level_d == '0);
    af_d    = (level_d >= AF_LVL);
    ae_d    = (level_d <= AE_LVL);

    ovf_d = bus.clr_err ? 1'b0 : (ovf_q | (bus.wr_en & full_q));
    unf_d = bus.clr_err ? 1'b0 : (unf_q | (bus.rd_en & empty_q));

    if (rd_acc) begin
      dout_d   = head;
      dvalid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      dout_q   <= '0;
      dvalid_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= bus.din;
  end

  assign bus.dout         = (FWFT != 0) ? head     : dout_q;
  assign bus.dout_valid   = (FWFT != 0) ? ~empty_q : dvalid_q;
  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = af_q;
  assign bus.almost_empty = ae_q;
  assign bus.level        = level_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;
endmodule

// File: tb/tb_dct_stream_fifo.sv
// Directed bench for dct_stream_fifo: a registered-read instance driven from a
// vector table, and an FWFT instance exercised with a streaming wrap sequence.
module tb_dct_stream_fifo;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  dct_stream_fifo_if #(.DATA_W(36), .DEPTH(4)) if0 ();
  dct_stream_fifo_if #(.DATA_W(36), .DEPTH(4)) if1 ();

  dct_stream_fifo #(.DATA_W(36), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(0))
    dut0 (.clk(clk), .rst(rst), .bus(if0));
  dct_stream_fifo #(.DATA_W(36), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(1))
    dut1 (.clk(clk), .rst(rst), .bus(if1));

  typedef struct {
    logic        wr, rd, clr;
    logic [35:0] din;
    logic [35:0] dout;
    logic        dv;
    int          lvl;
    logic        f, e, af, ae, o, u;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic wr, input logic rd, input logic clr, input logic [35:0] din,
                     input logic [35:0] dout, input logic dv, input int lvl,
                     input logic f, input logic e, input logic af, input logic ae,
                     input logic o, input logic u);
    vec_t v;
    v.wr = wr; v.rd = rd; v.clr = clr; v.din = din; v.dout = dout; v.dv = dv; v.lvl = lvl;
    v.f = f; v.e = e; v.af = af; v.ae = ae; v.o = o; v.u = u;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    if0.wr_en = 0; if0.rd_en = 0; if0.clr_err = 0; if0.din = '0;
    if1.wr_en = 0; if1.rd_en = 0; if1.clr_err = 0; if1.din = '0;

    //     wr rd clr din      dout   dv lvl f  e  af ae o  u
    add(1, 0, 0, 36'h1,  36'h0,  0, 1, 0, 0, 0, 1, 0, 0);
    add(1, 0, 0, 36'h2,  36'h0,  0, 2, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 36'h3,  36'h0,  0, 3, 0, 0, 1, 0, 0, 0);
    add(1, 0, 0, 36'h4,  36'h0,  0, 4, 1, 0, 1, 0, 0, 0);
    add(1, 0, 0, 36'hAA, 36'h0,  0, 4, 1, 0, 1, 0, 1, 0);
    add(0, 0, 1, 36'h0,  36'h0,  0, 4, 1, 0, 1, 0, 0, 0);
    add(0, 1, 0, 36'h0,  36'h1,  1, 3, 0, 0, 1, 0, 0, 0);
    add(0, 1, 0, 36'h0,  36'h2,  1, 2, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 36'h0,  36'h2,  0, 2, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 36'h0,  36'h3,  1, 1, 0, 0, 0, 1, 0, 0);
    add(0, 1, 0, 36'h0,  36'h4,  1, 0, 0, 1, 0, 1, 0, 0);
    add(0, 1, 0, 36'h0,  36'h4,  0, 0, 0, 1, 0, 1, 0, 1);
    add(1, 1, 0, 36'h66, 36'h4,  0, 1, 0, 0, 0, 1, 0, 1);
    add(0, 0, 1, 36'h0,  36'h4,  0, 1, 0, 0, 0, 1, 0, 0);
    add(0, 1, 0, 36'h0,  36'h66, 1, 0, 0, 1, 0, 1, 0, 0);
    add(0, 1, 1, 36'h0,  36'h66, 0, 0, 0, 1, 0, 1, 0, 0);
    add(1, 0, 0, 36'h21, 36'h66, 0, 1, 0, 0, 0, 1, 0, 0);
    add(1, 0, 0, 36'h22, 36'h66, 0, 2, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 36'h23, 36'h66, 0, 3, 0, 0, 1, 0, 0, 0);
    add(1, 0, 0, 36'h24, 36'h66, 0, 4, 1, 0, 1, 0, 0, 0);
    add(1, 1, 0, 36'h55, 36'h21, 1, 3, 0, 0, 1, 0, 1, 0);
    add(1, 1, 0, 36'h25, 36'h22, 1, 3, 0, 0, 1, 0, 1, 0);
    add(0, 1, 0, 36'h0,  36'h23, 1, 2, 0, 0, 0, 0, 1, 0);
    add(0, 1, 0, 36'h0,  36'h24, 1, 1, 0, 0, 0, 1, 1, 0);
    add(0, 1, 0, 36'h0,  36'h25, 1, 0, 0, 1, 0, 1, 1, 0);

    repeat (2) @(posedge clk);
    #1 rst = 0;
    #1;
    chk("rst.dout",  64'(if0.dout), 64'h0);
    chk("rst.dv",    64'(if0.dout_valid), 64'd0);
    chk("rst.full",  64'(if0.full), 64'd0);
    chk("rst.empty", 64'(if0.empty), 64'd1);
    chk("rst.af",    64'(if0.almost_full), 64'd0);
    chk("rst.ae",    64'(if0.almost_empty), 64'd1);
    chk("rst.level", 64'(if0.level), 64'd0);
    chk("rst.ovf",   64'(if0.overflow), 64'd0);
    chk("rst.unf",   64'(if0.underflow), 64'd0);
    chk("rst1.dv",   64'(if1.dout_valid), 64'd0);
    chk("rst1.empty", 64'(if1.empty), 64'd1);

    foreach (vq[i]) begin
      if0.wr_en = vq[i].wr; if0.rd_en = vq[i].rd; if0.clr_err = vq[i].clr; if0.din = vq[i].din;
      tick();
      chk($sformatf("v%0d.dout", i),  64'(if0.dout), 64'(vq[i].dout));
      chk($sformatf("v%0d.dv", i),    64'(if0.dout_valid), 64'(vq[i].dv));
      chk($sformatf("v%0d.level", i), 64'(if0.level), 64'(vq[i].lvl));
      chk($sformatf("v%0d.full", i),  64'(if0.full), 64'(vq[i].f));
      chk($sformatf("v%0d.empty", i), 64'(if0.empty), 64'(vq[i].e));
      chk($sformatf("v%0d.af", i),    64'(if0.almost_full), 64'(vq[i].af));
      chk($sformatf("v%0d.ae", i),    64'(if0.almost_empty), 64'(vq[i].ae));
      chk($sformatf("v%0d.ovf", i),   64'(if0.overflow), 64'(vq[i].o));
      chk($sformatf("v%0d.unf", i),   64'(if0.underflow), 64'(vq[i].u));
    end
    if0.wr_en = 0; if0.rd_en = 0; if0.clr_err = 0;

    // FWFT streaming: prime two words, then read and write every cycle.
    if1.wr_en = 1; if1.din = 36'h10;
    tick();
    chk("fwft.first_dv",   64'(if1.dout_valid), 64'd1);
    chk("fwft.first_dout", 64'(if1.dout), 64'h10);
    if1.din = 36'h11;
    tick();
    chk("fwft.prime_level", 64'(if1.level), 64'd2);
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("fwft.k%0d.dout", k), 64'(if1.dout), 64'h10 + 64'(k));
      chk($sformatf("fwft.k%0d.dv", k),   64'(if1.dout_valid), 64'd1);
      if1.rd_en = 1;
      if1.wr_en = (k < 8);
      if1.din   = 36'h12 + 36'(k);
      tick();
      chk($sformatf("fwft.k%0d.level", k), 64'(if1.level), (k < 8) ? 64'd2 : 64'(9 - k));
      chk($sformatf("fwft.k%0d.dv_track", k), 64'(if1.dout_valid), (k < 9) ? 64'd1 : 64'd0);
    end
    if1.rd_en = 0; if1.wr_en = 0;
    chk("fwft.end_empty", 64'(if1.empty), 64'd1);
    chk("fwft.end_unf",   64'(if1.underflow), 64'd0);
    chk("fwft.end_ovf",   64'(if1.overflow), 64'd0);

    // Asynchronous reset with three words stored.
    if0.wr_en = 1;
    for (int k = 0; k < 3; k++) begin
      if0.din = 36'h31 + 36'(k);
      tick();
    end
    if0.wr_en = 0;
    chk("mid.pre_level", 64'(if0.level), 64'd3);
    #2 rst = 1;
    #1;
    chk("mid.empty", 64'(if0.empty), 64'd1);
    chk("mid.level", 64'(if0.level), 64'd0);
    chk("mid.af",    64'(if0.almost_full), 64'd0);
    #1 rst = 0;
    if0.wr_en = 1; if0.din = 36'h77;
    tick();
    chk("mid.wr_level", 64'(if0.level), 64'd1);
    if0.wr_en = 0; if0.rd_en = 1;
    tick();
    chk("mid.rd_dout", 64'(if0.dout), 64'h77);
    chk("mid.rd_dv",   64'(if0.dout_valid), 64'd1);
    if0.rd_en = 0;
    tick();
    chk("mid.dv_drop", 64'(if0.dout_valid), 64'd0);
    chk("mid.empty2",  64'(if0.empty), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
